// File: rtl/instruction_register.sv
// JTAG instruction register: capture/shift stage plus a validated update stage.
// Optional IR_CAPTURE_STATUS_EN adds a status port whose bits are captured above the fixed 01 LSBs.
module instruction_register #(
  parameter int unsigned     WIDTH     = 6,
  parameter logic [WIDTH-1:0] IDCODE_OP = WIDTH'(6'b001000)
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             tlr,
  input  logic             capture_ir,
  input  logic             shift_ir,
  input  logic             update_ir,
  input  logic             tdi,
`ifdef IR_CAPTURE_STATUS_EN
  input  logic [WIDTH-3:0] status,
`endif
  output logic             tdo_ir,
  output logic [WIDTH-1:0] instruction_reg
);

  localparam int unsigned STATUS_W = WIDTH - 2;

  localparam logic [WIDTH-1:0] OP_BYPASS  = '1;
  localparam logic [WIDTH-1:0] OP_SAMPLE  = WIDTH'(6'b000010);
  localparam logic [WIDTH-1:0] OP_EXTEST  = WIDTH'(6'b000100);
  localparam logic [WIDTH-1:0] OP_IDCODE  = WIDTH'(6'b001000);
  localparam logic [WIDTH-1:0] OP_CLAMP   = WIDTH'(6'b010000);
  localparam logic [WIDTH-1:0] OP_ICRESET = WIDTH'(6'b100000);
  localparam logic [WIDTH-1:0] CAPTURE_LSB = WIDTH'(2'b01);

  logic [WIDTH-1:0]    ir_shift;
  logic [WIDTH-1:0]    ir_shift_nxt;
  logic [WIDTH-1:0]    instr_nxt;
  logic [WIDTH-1:0]    capture_val;
  logic [STATUS_W-1:0] capture_hi;
  logic                opcode_known;

`ifdef IR_CAPTURE_STATUS_EN
  assign capture_hi = status;
`else
  assign capture_hi = '0;
`endif

  // Fixed 01 in the LSBs lets the board-level tester verify IR chain integrity.
  assign capture_val = {capture_hi, 2'b01};

  // Only the opcodes the decoder understands may pass; anything else becomes BYPASS.
  always_comb begin
    opcode_known = 1'b0;
    unique case (ir_shift)
      OP_BYPASS, OP_SAMPLE, OP_EXTEST,
      OP_IDCODE, OP_CLAMP, OP_ICRESET: opcode_known = 1'b1;
      default:                         opcode_known = 1'b0;
    endcase
  end

  // Next-state: tlr > update_ir > shift_ir > capture_ir, one operation per edge.
  always_comb begin
    ir_shift_nxt = ir_shift;
    instr_nxt    = instruction_reg;
    if (tlr) begin
      instr_nxt = IDCODE_OP;
    end else if (update_ir) begin
      instr_nxt = opcode_known ? ir_shift : OP_BYPASS;
    end else if (shift_ir) begin
      ir_shift_nxt = {tdi, ir_shift[WIDTH-1:1]};
    end else if (capture_ir) begin
      ir_shift_nxt = capture_val;
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_shift        <= CAPTURE_LSB;
      instruction_reg <= IDCODE_OP;
    end else begin
      ir_shift        <= ir_shift_nxt;
      instruction_reg <= instr_nxt;
    end
  end

  assign tdo_ir = ir_shift[0];

endmodule

// File: tb/tb_instruction_register.sv
// Self-checking bench for instruction_register: directed scenarios plus randomized
// TAP-control traffic compared against an integer-arithmetic reference model.
module tb_instruction_register;

  localparam int W = 6;

  logic         tck = 1'b0;
  logic         trst, tlr, capture_ir, shift_ir, update_ir, tdi;
  logic [W-3:0] status;
  logic         tdo_ir;
  logic [W-1:0] instruction_reg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state held as plain integers.
  int m_sh;
  int m_ir;
  int known_ops[6] = '{63, 2, 4, 8, 16, 32};

  instruction_register #(.WIDTH(W), .IDCODE_OP(6'b001000)) dut (
    .tck(tck), .trst(trst), .tlr(tlr), .capture_ir(capture_ir),
    .shift_ir(shift_ir), .update_ir(update_ir), .tdi(tdi),
`ifdef IR_CAPTURE_STATUS_EN
    .status(status),
`endif
    .tdo_ir(tdo_ir), .instruction_reg(instruction_reg)
  );

  always #5 tck = ~tck;

  function automatic bit is_known(input int v);
    foreach (known_ops[i]) if (known_ops[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int capture_value();
`ifdef IR_CAPTURE_STATUS_EN
    return int'(status) * 4 + 1;
`else
    return 1;
`endif
  endfunction

  // Model of one tck edge under the requested control combination.
  task automatic model_edge(input bit t, input bit u, input bit s, input bit c, input bit d);
    if (t)      m_ir = 8;
    else if (u) m_ir = is_known(m_sh) ? m_sh : 63;
    else if (s) m_sh = m_sh / 2 + (d ? 32 : 0);
    else if (c) m_sh = capture_value();
  endtask

  // Apply controls for one edge, advance the model, settle 1 time unit after the edge.
  task automatic step(input bit t, input bit u, input bit s, input bit c, input bit d);
    tlr = t; update_ir = u; shift_ir = s; capture_ir = c; tdi = d;
    @(posedge tck);
    #1;
    model_edge(t, u, s, c, d);
    tlr = 0; update_ir = 0; shift_ir = 0; capture_ir = 0; tdi = 0;
  endtask

  task automatic do_reset();
    @(posedge tck); #1;
    trst = 1'b0;
    #2;
    m_sh = 1; m_ir = 8;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (instruction_reg !== 6'b001000) begin
      n_fail++; $display("FAIL reset_ir: got %b expected 001000", instruction_reg);
    end
    n_checks++;
    if (tdo_ir !== 1'b1) begin
      n_fail++; $display("FAIL reset_tdo: got %b expected 1", tdo_ir);
    end
    #3 trst = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    n_checks++;
    if (instruction_reg !== 6'b001000) begin
      n_fail++; $display("FAIL reset_idle_ir: got %b expected 001000", instruction_reg);
    end
  endtask

  task automatic test_capture_shift();
    bit exp_seq[6] = '{1, 0, 0, 0, 0, 0};
    status = 4'b0000;
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (tdo_ir !== exp_seq[i] || int'(tdo_ir) != m_sh % 2) begin
        n_fail++; $display("FAIL capture_shift_tdo[%0d]: got %b expected %0d", i, tdo_ir, exp_seq[i]);
      end
      step(0, 0, 1, 0, 0);
    end
  endtask

  // Shift a value LSB first and check the update stage is untouched meanwhile.
  task automatic shift_word(input int val, input string tag);
    logic [W-1:0] held;
    held = instruction_reg;
    for (int i = 0; i < W; i++) begin
      step(0, 0, 1, 0, ((val >> i) & 1) != 0);
      n_checks++;
      if (instruction_reg !== held) begin
        n_fail++; $display("FAIL %s_hold[%0d]: got %b expected %b", tag, i, instruction_reg, held);
      end
    end
  endtask

  task automatic test_load_extest();
    shift_word(6'b000100, "extest");
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (instruction_reg !== 6'b000100 || int'(instruction_reg) != m_ir) begin
      n_fail++; $display("FAIL extest_load: got %b expected 000100", instruction_reg);
    end
  endtask

  task automatic test_unrecognised();
    shift_word(6'b000011, "unrec");
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (instruction_reg !== 6'b111111) begin
      n_fail++; $display("FAIL unrecognised: got %b expected 111111", instruction_reg);
    end
    // Every known opcode must pass through unchanged.
    foreach (known_ops[k]) begin
      shift_word(known_ops[k], "known");
      step(0, 1, 0, 0, 0);
      n_checks++;
      if (int'(instruction_reg) != known_ops[k]) begin
        n_fail++; $display("FAIL known_op: got %b expected %0d", instruction_reg, known_ops[k]);
      end
    end
  endtask

  task automatic test_simultaneous();
    shift_word(6'b010000, "clamp");
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    n_checks++;
    if (instruction_reg !== 6'b001000) begin
      n_fail++; $display("FAIL tlr_over_update: got %b expected 001000", instruction_reg);
    end
    // ir_shift still holds 010000; shift with capture must shift in a 1, not capture.
    step(0, 0, 1, 1, 1);
    n_checks++;
    if (m_sh != 40 || tdo_ir !== 1'b0) begin
      n_fail++; $display("FAIL shift_over_capture_tdo: got %b expected 0", tdo_ir);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    n_checks++;
    if (tdo_ir !== 1'b1) begin
      n_fail++; $display("FAIL shift_over_capture_bit3: got %b expected 1", tdo_ir);
    end
  endtask

  task automatic test_trst_midshift();
    shift_word(6'b000100, "pre");
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    do_reset();
    n_checks++;
    if (instruction_reg !== 6'b001000 || tdo_ir !== 1'b1) begin
      n_fail++; $display("FAIL trst_midshift: got ir=%b tdo=%b expected 001000/1", instruction_reg, tdo_ir);
    end
    #3 trst = 1'b1;
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (instruction_reg !== 6'b111111) begin
      n_fail++; $display("FAIL trst_no_partial: got %b expected 111111", instruction_reg);
    end
  endtask

`ifdef IR_CAPTURE_STATUS_EN
  task automatic test_status_capture();
    bit exp_seq[6] = '{1, 0, 0, 1, 0, 1};
    status = 4'b1010;
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (tdo_ir !== exp_seq[i]) begin
        n_fail++; $display("FAIL status_capture[%0d]: got %b expected %0d", i, tdo_ir, exp_seq[i]);
      end
      step(0, 0, 1, 0, 0);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      status = 4'($urandom);
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 0,  $urandom_range(0, 5) == 0, 1'($urandom));
      n_checks++;
      if (int'(instruction_reg) != m_ir || int'(tdo_ir) != m_sh % 2) begin
        n_fail++; $display("FAIL random[%0d]: got ir=%b tdo=%b expected ir=%0d tdo=%0d",
                           n, instruction_reg, tdo_ir, m_ir, m_sh % 2);
      end
    end
  endtask

  initial begin
    trst = 1'b1; tlr = 0; capture_ir = 0; shift_ir = 0; update_ir = 0; tdi = 0;
    status = '0;
    m_sh = 1; m_ir = 8;
    test_reset();
    test_capture_shift();
    test_load_extest();
    test_unrecognised();
    test_simultaneous();
    test_trst_midshift();
`ifdef IR_CAPTURE_STATUS_EN
    test_status_capture();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
